// File: rtl/lsu_pkg.sv
// Shared types and helpers for the memory-stage load/store unit.
// Holds the FSM state encoding, access-size codes and the byte-lane / store-data lane helpers.
// Used by lsu_mem_stage (bus side) and lsu_load_align (load extraction).
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_t;

  // Access size, taken from funct3[1:0]; 2'b11 is treated as a word.
  localparam logic [1:0] LS_BYTE = 2'b00;
  localparam logic [1:0] LS_HALF = 2'b01;
  localparam logic [1:0] LS_WORD = 2'b10;

  // Byte enables for a word-aligned 32-bit bus, lanes picked by the low address bits.
  function automatic logic [3:0] be_gen(input logic [1:0] size, input logic [1:0] addr_lo);
    logic [3:0] be;
    case (size)
      LS_BYTE: be = 4'b0001 << addr_lo;
      LS_HALF: be = 4'b0011 << {addr_lo[1], 1'b0};
      default: be = 4'hF;
    endcase
    return be;
  endfunction

  // Replicate the LSB-aligned store data across every lane so the enabled lane(s) see it.
  function automatic logic [31:0] wdata_rep(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] rep;
    case (size)
      LS_BYTE: rep = {4{wdata[7:0]}};
      LS_HALF: rep = {2{wdata[15:0]}};
      default: rep = wdata;
    endcase
    return rep;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data aligner: selects byte/half/word lanes of the bus read word and sign/zero extends.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the result is captured.
module lsu_load_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_rdata,
  input  logic [1:0]      i_addr_lo,
  input  logic [2:0]      i_funct3,
  output logic [XLEN-1:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_sign;

  // Lane select by address, then extend; funct3[2] chooses zero extension.
  always_comb begin
    w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
    w_half = i_rdata[{i_addr_lo[1], 4'b0000} +: 16];
    w_sign = 1'b0;
    o_data = i_rdata;
    case (i_funct3[1:0])
      LS_BYTE: begin
        w_sign = w_byte[7] & ~i_funct3[2];
        o_data = {{(XLEN-8){w_sign}}, w_byte};
      end
      LS_HALF: begin
        w_sign = w_half[15] & ~i_funct3[2];
        o_data = {{(XLEN-16){w_sign}}, w_half};
      end
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// Memory-stage load/store responder: turns M-stage controls into a req/gnt data-bus access.
// Latency: store >= 2 stall cycles, load >= 3; each grant/rvalid delay cycle adds one stall.
// Backpressure: stall_MW holds M/W while the access is in flight; bus_req held until bus_gnt.
// Optional LSU_MISALIGN_TRAP_EN: misaligned half/word accesses are not issued and flag misalign.
module lsu_mem_stage
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cs_M,
  input  logic            rd_en_M,
  input  logic            mem_write_M,
  input  logic [XLEN-1:0] addr_M,
  input  logic [XLEN-1:0] wdata_M,
  input  logic [2:0]      funct3_M,
  output logic            stall_MW,
  output logic [XLEN-1:0] rdata_W,
  output logic            rdata_valid,
  output logic            bus_req,
  output logic            bus_we,
  output logic [XLEN-1:0] bus_addr,
  output logic [XLEN-1:0] bus_wdata,
  output logic [3:0]      bus_be,
  input  logic            bus_gnt,
  input  logic            bus_rvalid,
  input  logic [XLEN-1:0] bus_rdata
`ifdef LSU_MISALIGN_TRAP_EN
  ,
  output logic            misalign
`endif
);

  lsu_state_t      r_state;
  logic            r_bus_req;
  logic            r_bus_we;
  logic [XLEN-1:0] r_bus_addr;
  logic [XLEN-1:0] r_bus_wdata;
  logic [3:0]      r_bus_be;
  logic [2:0]      r_funct3;
  logic [1:0]      r_addr_lo;
  logic [XLEN-1:0] r_rdata;
  logic            r_rdata_valid;
  logic            w_access;
  logic [XLEN-1:0] w_load_ext;

  // A write wins over a simultaneous read request.
  assign w_access = ~cs_M & (rd_en_M | mem_write_M);

`ifdef LSU_MISALIGN_TRAP_EN
  logic r_misalign;
  logic w_misalign;

  // Half needs addr[0]=0, word needs addr[1:0]=0; bytes are always aligned.
  always_comb begin
    w_misalign = 1'b0;
    case (funct3_M[1:0])
      LS_BYTE: w_misalign = 1'b0;
      LS_HALF: w_misalign = addr_M[0];
      default: w_misalign = |addr_M[1:0];
    endcase
  end

  assign misalign = r_misalign;
`endif

  lsu_load_align #(.XLEN(XLEN)) u_align (
    .i_rdata   (bus_rdata),
    .i_addr_lo (r_addr_lo),
    .i_funct3  (r_funct3),
    .o_data    (w_load_ext)
  );

  // Stall is combinational so the pipeline freezes in the very cycle the access appears.
  always_comb begin
    stall_MW = 1'b0;
    case (r_state)
      ST_IDLE: stall_MW = w_access;
      ST_REQ:  stall_MW = 1'b1;
      ST_WAIT: stall_MW = 1'b1;
      ST_DONE: stall_MW = 1'b0;
      default: stall_MW = 1'b0;
    endcase
  end

  // Access FSM with registered bus fields; DONE always returns to IDLE so no access launches from it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_bus_req     <= 1'b0;
      r_bus_we      <= 1'b0;
      r_bus_addr    <= '0;
      r_bus_wdata   <= '0;
      r_bus_be      <= 4'h0;
      r_funct3      <= 3'b000;
      r_addr_lo     <= 2'b00;
      r_rdata       <= '0;
      r_rdata_valid <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      r_misalign    <= 1'b0;
`endif
    end else begin
      r_rdata_valid <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      r_misalign    <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          if (w_access) begin
`ifdef LSU_MISALIGN_TRAP_EN
            if (w_misalign) begin
              r_misalign <= 1'b1;
              r_state    <= ST_DONE;
            end else
`endif
            begin
              r_bus_req   <= 1'b1;
              r_bus_we    <= mem_write_M;
              r_bus_addr  <= {addr_M[XLEN-1:2], 2'b00};
              r_bus_wdata <= wdata_rep(funct3_M[1:0], wdata_M);
              r_bus_be    <= be_gen(funct3_M[1:0], addr_M[1:0]);
              r_funct3    <= funct3_M;
              r_addr_lo   <= addr_M[1:0];
              r_state     <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (bus_gnt) begin
            r_bus_req <= 1'b0;
            r_state   <= r_bus_we ? ST_DONE : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (bus_rvalid) begin
            r_rdata       <= w_load_ext;
            r_rdata_valid <= 1'b1;
            r_state       <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus_req     = r_bus_req;
  assign bus_we      = r_bus_we;
  assign bus_addr    = r_bus_addr;
  assign bus_wdata   = r_bus_wdata;
  assign bus_be      = r_bus_be;
  assign rdata_W     = r_rdata;
  assign rdata_valid = r_rdata_valid;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage: vector table of loads/stores plus hand sequences.
// A small bus responder grants after a per-vector delay and returns read data.
// Also covers reset in WAIT and, with LSU_MISALIGN_TRAP_EN, the misalign trap.
module tb_lsu_mem_stage;

  logic        clk;
  logic        reset;
  logic        cs_M, rd_en_M, mem_write_M;
  logic [31:0] addr_M, wdata_M;
  logic [2:0]  funct3_M;
  logic        stall_MW;
  logic [31:0] rdata_W;
  logic        rdata_valid;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_gnt, bus_rvalid;
  logic [31:0] bus_rdata;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        misalign;
`endif

  int n_checks = 0;
  int n_errors = 0;

  lsu_mem_stage #(.XLEN(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .cs_M        (cs_M),
    .rd_en_M     (rd_en_M),
    .mem_write_M (mem_write_M),
    .addr_M      (addr_M),
    .wdata_M     (wdata_M),
    .funct3_M    (funct3_M),
    .stall_MW    (stall_MW),
    .rdata_W     (rdata_W),
    .rdata_valid (rdata_valid),
    .bus_req     (bus_req),
    .bus_we      (bus_we),
    .bus_addr    (bus_addr),
    .bus_wdata   (bus_wdata),
    .bus_be      (bus_be),
    .bus_gnt     (bus_gnt),
    .bus_rvalid  (bus_rvalid),
    .bus_rdata   (bus_rdata)
`ifdef LSU_MISALIGN_TRAP_EN
    ,
    .misalign    (misalign)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          gnt_dly;
    int          rv_dly;
    logic [3:0]  exp_be;
    logic [31:0] exp_baddr;
    logic [31:0] exp_bwdata;
    logic [31:0] exp_rdw;
    int          exp_stall;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic wr, logic rd, logic [2:0] f3, logic [31:0] addr,
                              logic [31:0] wdata, logic [31:0] rdata, int gd, int rvd,
                              logic [3:0] be, logic [31:0] baddr, logic [31:0] bwdata,
                              logic [31:0] rdw, int st);
    vec_t v;
    v.wr = wr; v.rd = rd; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
    v.gnt_dly = gd; v.rv_dly = rvd; v.exp_be = be; v.exp_baddr = baddr;
    v.exp_bwdata = bwdata; v.exp_rdw = rdw; v.exp_stall = st;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Runs one access starting at a negedge; leaves inputs idle at a negedge on return.
  task automatic run_vec(input int idx, input vec_t v);
    int  stall_cnt = 0, valid_cnt = 0, req_cnt = 0, rv_cnt = 0, req_in_wait = 0;
    bit  granted = 0, fields_done = 0, done = 0;
    string tag;
    tag = $sformatf("v%0d", idx);
    cs_M = 1'b0; rd_en_M = v.rd; mem_write_M = v.wr;
    addr_M = v.addr; wdata_M = v.wdata; funct3_M = v.f3;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      #1;
      if (rdata_valid) valid_cnt++;
      if (stall_MW) stall_cnt++;
      else if (stall_cnt > 0) done = 1;
      bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h5EAD_BAAD;
      if (bus_req && !granted) begin
        if (!fields_done) begin
          chk({tag, " bus_addr"}, bus_addr, v.exp_baddr);
          chk({tag, " bus_be"}, {28'h0, bus_be}, {28'h0, v.exp_be});
          chk({tag, " bus_wdata"}, bus_wdata, v.exp_bwdata);
          chk({tag, " bus_we"}, {31'h0, bus_we}, {31'h0, v.wr});
          fields_done = 1;
        end
        if (req_cnt == v.gnt_dly) begin
          bus_gnt = 1'b1;
          granted = 1;
        end else begin
          bus_rvalid = 1'b1;  // stray response while in REQ must be ignored
        end
        req_cnt++;
      end else if (granted && !v.wr) begin
        if (bus_req) req_in_wait++;
        if (rv_cnt == v.rv_dly) bus_rdata = v.rdata;
        bus_rvalid = (rv_cnt <= v.rv_dly) ? (rv_cnt == v.rv_dly) : 1'b1;
        rv_cnt++;
      end
      @(negedge clk);
    end
    bus_gnt = 1'b0; bus_rvalid = 1'b0;
    cs_M = 1'b1; rd_en_M = 1'b0; mem_write_M = 1'b0;
    if (!done) begin
      n_checks++; n_errors++;
      $display("FAIL %s timeout: got no DONE, expected completion within 40 cycles", tag);
    end
    chk({tag, " stall_cycles"}, stall_cnt, v.exp_stall);
    chk({tag, " rdata_valid_pulses"}, valid_cnt, v.wr ? 0 : 1);
    chk({tag, " req_during_wait"}, req_in_wait, 0);
    #1;
    chk({tag, " rdata_W"}, rdata_W, v.exp_rdw);
  endtask

  initial begin
    reset = 1'b1; cs_M = 1'b1; rd_en_M = 1'b0; mem_write_M = 1'b0;
    addr_M = '0; wdata_M = '0; funct3_M = 3'b000;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;

    //            wr rd f3      addr        wdata         rdata       gd rv be    baddr         bwdata        rdata_W       stall
    vecs.push_back(mk(1, 0, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0,        0, 0, 4'hF, 32'h100, 32'hDEADBEEF, 32'h0,        2));
    vecs.push_back(mk(1, 1, 3'b000, 32'h103, 32'h000000A5, 32'h0,        0, 0, 4'h8, 32'h100, 32'hA5A5A5A5, 32'h0,        2));
    vecs.push_back(mk(0, 1, 3'b000, 32'h102, 32'h0,        32'h12803456, 2, 0, 4'h4, 32'h100, 32'h0,        32'hFFFFFF80, 5));
    vecs.push_back(mk(0, 1, 3'b100, 32'h102, 32'h0,        32'h12803456, 2, 0, 4'h4, 32'h100, 32'h0,        32'h00000080, 5));
    vecs.push_back(mk(1, 0, 3'b001, 32'h202, 32'h1234BEEF, 32'h0,        1, 0, 4'hC, 32'h200, 32'hBEEFBEEF, 32'h00000080, 3));
    vecs.push_back(mk(0, 1, 3'b001, 32'h206, 32'h0,        32'h80017FFF, 0, 2, 4'hC, 32'h204, 32'h0,        32'hFFFF8001, 5));
    vecs.push_back(mk(0, 1, 3'b101, 32'h204, 32'h0,        32'h80017FFF, 0, 0, 4'h3, 32'h204, 32'h0,        32'h00007FFF, 3));
    vecs.push_back(mk(0, 1, 3'b010, 32'h300, 32'h0,        32'hCAFEF00D, 0, 1, 4'hF, 32'h300, 32'h0,        32'hCAFEF00D, 4));
    vecs.push_back(mk(1, 0, 3'b000, 32'h301, 32'hFFFFFF5A, 32'h0,        0, 0, 4'h2, 32'h300, 32'h5A5A5A5A, 32'hCAFEF00D, 2));
    vecs.push_back(mk(0, 1, 3'b000, 32'h301, 32'h0,        32'h00007F00, 1, 0, 4'h2, 32'h300, 32'h0,        32'h0000007F, 4));
`ifndef LSU_MISALIGN_TRAP_EN
    vecs.push_back(mk(0, 1, 3'b001, 32'h103, 32'h0,        32'hA5B60000, 0, 0, 4'hC, 32'h100, 32'h0,        32'hFFFFA5B6, 3));
`endif

    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset stall_MW", {31'h0, stall_MW}, 32'h0);
    chk("reset bus_req", {31'h0, bus_req}, 32'h0);
    chk("reset bus_we", {31'h0, bus_we}, 32'h0);
    chk("reset bus_addr", bus_addr, 32'h0);
    chk("reset bus_wdata", bus_wdata, 32'h0);
    chk("reset bus_be", {28'h0, bus_be}, 32'h0);
    chk("reset rdata_W", rdata_W, 32'h0);
    chk("reset rdata_valid", {31'h0, rdata_valid}, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("reset misalign", {31'h0, misalign}, 32'h0);
`endif

    // Selected but no direction, and direction but not selected: no access either way.
    @(negedge clk);
    cs_M = 1'b0; rd_en_M = 1'b0; mem_write_M = 1'b0;
    #1 chk("no_dir stall_MW", {31'h0, stall_MW}, 32'h0);
    @(negedge clk);
    cs_M = 1'b1; rd_en_M = 1'b1;
    #1 chk("cs_high stall_MW", {31'h0, stall_MW}, 32'h0);
    chk("no_dir bus_req", {31'h0, bus_req}, 32'h0);
    @(negedge clk);
    #1 chk("cs_high bus_req", {31'h0, bus_req}, 32'h0);
    rd_en_M = 1'b0;
    @(negedge clk);

    // Consecutive vectors run with no idle bubble between them.
    for (int i = 0; i < vecs.size(); i++) run_vec(i, vecs[i]);

    // Reset while waiting for read data; the late response must be dropped.
    @(negedge clk);
    cs_M = 1'b0; rd_en_M = 1'b1; addr_M = 32'h104; funct3_M = 3'b010;
    @(negedge clk);
    #1 chk("rst_seq bus_req in REQ", {31'h0, bus_req}, 32'h1);
    bus_gnt = 1'b1;
    @(negedge clk);
    bus_gnt = 1'b0;
    #1 chk("rst_seq stall in WAIT", {31'h0, stall_MW}, 32'h1);
    reset = 1'b1; cs_M = 1'b1; rd_en_M = 1'b0;
    bus_rvalid = 1'b1; bus_rdata = 32'h11223344;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_seq bus_req", {31'h0, bus_req}, 32'h0);
    chk("rst_seq stall_MW", {31'h0, stall_MW}, 32'h0);
    chk("rst_seq rdata_W", rdata_W, 32'h0);
    chk("rst_seq bus_addr", bus_addr, 32'h0);
    @(negedge clk);
    bus_rvalid = 1'b0;
    #1;
    chk("rst_seq late rdata_W", rdata_W, 32'h0);
    chk("rst_seq late rdata_valid", {31'h0, rdata_valid}, 32'h0);

`ifdef LSU_MISALIGN_TRAP_EN
    // Misaligned half load: trapped in one stall cycle, never reaches the bus.
    @(negedge clk);
    cs_M = 1'b0; rd_en_M = 1'b1; addr_M = 32'h101; funct3_M = 3'b001;
    #1 chk("mis stall in IDLE", {31'h0, stall_MW}, 32'h1);
    @(negedge clk);
    #1;
    chk("mis misalign", {31'h0, misalign}, 32'h1);
    chk("mis stall in DONE", {31'h0, stall_MW}, 32'h0);
    chk("mis bus_req", {31'h0, bus_req}, 32'h0);
    cs_M = 1'b1; rd_en_M = 1'b0;
    @(negedge clk);
    #1;
    chk("mis misalign clears", {31'h0, misalign}, 32'h0);
    chk("mis bus_req after", {31'h0, bus_req}, 32'h0);
    chk("mis rdata_W", rdata_W, 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
